// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move results, HI/LO registers and a restoring
// divider for DIV/DIVU that stalls the pipeline while it iterates.
module ex_stage #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

  localparam int              CNT_W    = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      divisor_q, divisor_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      rem_q, rem_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dzero_q, dzero_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        is_div, is_sdiv;
  logic [31:0] op1_abs, op2_abs;
  logic [32:0] step_sh;
  logic        step_borrow;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] result;

  assign is_sdiv = (aluop_i == EXE_DIV_OP);
  assign is_div  = is_sdiv || (aluop_i == EXE_DIVU_OP);
  assign op1_abs = (is_sdiv && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
  assign op2_abs = (is_sdiv && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

  // Remainder below divisor is invariant, so the shifted pair fits in 33 bits.
  assign step_sh     = {rem_q, quot_q[31]};
  assign step_borrow = (step_sh < {1'b0, divisor_q});

  assign quot_fix = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
  assign rem_fix  = neg_rem_q  ? (~rem_q + 32'd1)  : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (is_div) state_d = (reg2_i == 32'd0) ? DONE : BUSY;
        BUSY: if (cnt_q == CNT_LAST) state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    if (!rst && !flush_i) begin
      unique case (state_q)
        IDLE:    stallreq_o = is_div;
        BUSY:    stallreq_o = 1'b1;
        default: stallreq_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dzero_d    = dzero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (!flush_i) begin
      unique case (state_q)
        IDLE: begin
          if (is_div) begin
            cnt_d      = '0;
            divisor_d  = op2_abs;
            quot_d     = op1_abs;
            rem_d      = 32'd0;
            neg_quot_d = is_sdiv && (reg1_i[31] ^ reg2_i[31]);
            neg_rem_d  = is_sdiv && reg1_i[31];
            dzero_d    = (reg2_i == 32'd0);
          end
        end
        BUSY: begin
          quot_d = {quot_q[30:0], ~step_borrow};
          rem_d  = step_borrow ? step_sh[31:0] : (step_sh[31:0] - divisor_q);
          cnt_d  = cnt_q + CNT_W'(1);
        end
        DONE: begin
          hi_d = dzero_q ? 32'd0 : rem_fix;
          lo_d = dzero_q ? 32'd0 : quot_fix;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      divisor_q  <= 32'd0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dzero_q    <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      cnt_q      <= cnt_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dzero_q    <= dzero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_comb begin
    result = 32'd0;
    unique case (alusel_i)
      EXE_RES_LOGIC: begin
        unique case (aluop_i)
          EXE_AND_OP: result = reg1_i & reg2_i;
          EXE_OR_OP:  result = reg1_i | reg2_i;
          EXE_XOR_OP: result = reg1_i ^ reg2_i;
          EXE_NOR_OP: result = ~(reg1_i | reg2_i);
          default:    result = 32'd0;
        endcase
      end
      EXE_RES_SHIFT: begin
        unique case (aluop_i)
          EXE_SLL_OP: result = reg2_i << reg1_i[4:0];
          EXE_SRL_OP: result = reg2_i >> reg1_i[4:0];
          EXE_SRA_OP: result = $signed(reg2_i) >>> reg1_i[4:0];
          default:    result = 32'd0;
        endcase
      end
      EXE_RES_MOVE: begin
        unique case (aluop_i)
          EXE_MFHI_OP: result = hi_q;
          EXE_MFLO_OP: result = lo_q;
          default:     result = 32'd0;
        endcase
      end
      EXE_RES_NOP: result = (aluop_i == EXE_NOP_OP) ? 32'd0 : 32'd0;
      default:     result = 32'd0;
    endcase
  end

  assign wd_o    = rst ? 5'd0  : wd_i;
  assign wreg_o  = (rst || flush_i || is_div) ? 1'b0 : wreg_i;
  assign wdata_o = rst ? 32'd0 : result;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: combinational ops, divider latency and results,
// divide-by-zero, flush abort and asynchronous reset mid-division.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP  = 8'b0000_0000;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_MFHI = 8'b0001_0000;
  localparam logic [7:0] OP_MFLO = 8'b0001_0010;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int failures = 0;
  int n;

  ex_stage #(.DIV_ITER(32)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic w);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = w;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with stall high, starting in the issue cycle; bounded.
  task automatic count_stall(output int cnt);
    cnt = 0;
    while (stallreq_o === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0;
    aluop_i = OP_NOP; alusel_i = SEL_NOP; reg1_i = 0; reg2_i = 0; wd_i = 5'd9; wreg_i = 1'b1;
    #1;
    check("rst_stall", {31'd0, stallreq_o}, 32'd0);
    check("rst_wreg",  {31'd0, wreg_o}, 32'd0);
    check("rst_wd",    {27'd0, wd_o}, 32'd0);
    check("rst_hi",    hi_o, 32'd0);
    check("rst_lo",    lo_o, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    drive(OP_AND, SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd5, 1'b1);
    check("and_wdata", wdata_o, 32'h00F0_1234);
    check("and_wreg",  {31'd0, wreg_o}, 32'd1);
    check("and_wd",    {27'd0, wd_o}, 32'd5);
    check("and_stall", {31'd0, stallreq_o}, 32'd0);
    drive(OP_OR,  SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd5, 1'b1);
    check("or",  wdata_o, 32'hFFF0_FFFF);
    drive(OP_XOR, SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd5, 1'b1);
    check("xor", wdata_o, 32'hFF00_EDCB);
    drive(OP_NOR, SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd5, 1'b1);
    check("nor", wdata_o, 32'h000F_0000);
    drive(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0010, 5'd3, 1'b1);
    check("sra4", wdata_o, 32'hF800_0001);
    drive(OP_SRL, SEL_SHIFT, 32'd4, 32'h8000_0010, 5'd3, 1'b1);
    check("srl4", wdata_o, 32'h0800_0001);
    drive(OP_SLL, SEL_SHIFT, 32'hFFFF_FFE4, 32'h8000_0010, 5'd3, 1'b1);
    check("sll_sa_low5", wdata_o, 32'h0000_0100);
    drive(OP_SRA, SEL_SHIFT, 32'd31, 32'h8000_0010, 5'd3, 1'b1);
    check("sra31", wdata_o, 32'hFFFF_FFFF);
    drive(OP_SRL, SEL_SHIFT, 32'd0, 32'h8000_0010, 5'd3, 1'b1);
    check("srl0", wdata_o, 32'h8000_0010);
    drive(8'hEE, SEL_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
    check("unknown_op", wdata_o, 32'd0);
    drive(OP_AND, SEL_NOP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
    check("nop_sel", wdata_o, 32'd0);
    tick();

    // DIV -7 / 2
    drive(OP_DIV, SEL_NOP, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
    check("div_wreg_forced", {31'd0, wreg_o}, 32'd0);
    count_stall(n);
    check("div_stall_len", n, 32'd33);
    tick();
    drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd6, 1'b1);
    check("div_lo", lo_o, 32'hFFFF_FFFD);
    check("div_hi", hi_o, 32'hFFFF_FFFF);
    check("mflo",   wdata_o, 32'hFFFF_FFFD);
    drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd6, 1'b1);
    check("mfhi",   wdata_o, 32'hFFFF_FFFF);
    tick();

    // DIV 7 / -2
    drive(OP_DIV, SEL_NOP, 32'd7, 32'hFFFF_FFFE, 5'd4, 1'b1);
    count_stall(n);
    check("div2_stall_len", n, 32'd33);
    tick();
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    check("div2_lo", lo_o, 32'hFFFF_FFFD);
    check("div2_hi", hi_o, 32'd1);

    // DIVU 0xFFFFFFFF / 16
    drive(OP_DIVU, SEL_NOP, 32'hFFFF_FFFF, 32'h10, 5'd4, 1'b1);
    count_stall(n);
    check("divu_stall_len", n, 32'd33);
    tick();
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    check("divu_lo", lo_o, 32'h0FFF_FFFF);
    check("divu_hi", hi_o, 32'h0000_000F);

    // DIVU by zero
    drive(OP_DIVU, SEL_NOP, 32'd1234, 32'd0, 5'd4, 1'b1);
    count_stall(n);
    check("div0_stall_len", n, 32'd1);
    tick();
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    check("div0_lo", lo_o, 32'd0);
    check("div0_hi", hi_o, 32'd0);

    // Preload DIVU 100 / 7
    drive(OP_DIVU, SEL_NOP, 32'd100, 32'd7, 5'd4, 1'b1);
    count_stall(n);
    check("pre_stall_len", n, 32'd33);
    tick();
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    check("pre_lo", lo_o, 32'd14);
    check("pre_hi", hi_o, 32'd2);

    // Flush at BUSY cycle 5
    drive(OP_DIV, SEL_NOP, 32'd1000, 32'd3, 5'd4, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("flush_pre_stall", {31'd0, stallreq_o}, 32'd1);
    flush_i = 1'b1;
    #1;
    check("flush_stall", {31'd0, stallreq_o}, 32'd0);
    check("flush_wreg",  {31'd0, wreg_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    for (int i = 0; i < 40; i++) tick();
    check("flush_lo_kept", lo_o, 32'd14);
    check("flush_hi_kept", hi_o, 32'd2);

    // Async reset at BUSY cycle 10
    drive(OP_DIV, SEL_NOP, 32'd1000, 32'd3, 5'd7, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    check("rst_busy_stall_pre", {31'd0, stallreq_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy_stall", {31'd0, stallreq_o}, 32'd0);
    check("rst_busy_hi",    hi_o, 32'd0);
    check("rst_busy_lo",    lo_o, 32'd0);
    check("rst_busy_wd",    {27'd0, wd_o}, 32'd0);
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    drive(OP_DIVU, SEL_NOP, 32'd100, 32'd7, 5'd4, 1'b1);
    count_stall(n);
    check("post_rst_stall_len", n, 32'd33);
    tick();
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    check("post_rst_lo", lo_o, 32'd14);
    check("post_rst_hi", hi_o, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits directly downstream of the decode stage and consumes its aluop/alusel, source operands, and destination fields.
- Computes logic, shift, and HI/LO-move results combinationally. Results go to the EX/MEM register and are looped back to decode as the forwarding source (ex_wd/ex_wreg/ex_wdata).
- Owns the HI/LO registers and a 32-iteration restoring divider for DIV/DIVU. While a division is in progress it raises a stall request to the pipeline controller.

Parameters:
- DIV_ITER, 32, number of divider iterations (one quotient bit per cycle); fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  asynchronous, active-high reset (`RstEnable).
- aluop_i  in  8  operation subtype from decode (`EXE_*_OP`).
- alusel_i  in  3  operation class from decode (`EXE_RES_*`).
- reg1_i  in  32  source operand 1 (rs, or shift amount in imm).
- reg2_i  in  32  source operand 2 (rt or immediate).
- wd_i  in  5  destination register address.
- wreg_i  in  1  destination write enable.
- flush_i  in  1  cancel the instruction currently in EX; aborts an in-flight division.
- wd_o  out  5  destination address to EX/MEM and to decode forwarding.
- wreg_o  out  1  write enable to EX/MEM and to decode forwarding.
- wdata_o  out  32  result to EX/MEM and to decode forwarding.
- stallreq_o  out  1  1 = hold PC, IF/ID, and ID/EX; the instruction in EX is held.
- hi_o  out  32  current HI register.
- lo_o  out  32  current LO register.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; HI=LO=0; iteration counter=0; divider registers=0.
  - stallreq_o=0, wreg_o=0, wd_o=0, wdata_o=0, all immediately without waiting for a clock.
- Combinational result path:
  - wd_o=wd_i.
  - wreg_o=wreg_i, forced to 0 for DIV/DIVU and when flush_i=1.
- alusel LOGIC:
  - AND/OR/XOR give reg1&reg2, reg1|reg2, reg1^reg2.
  - NOR gives ~(reg1|reg2).
- alusel SHIFT, shift amount = reg1_i[4:0]:
  - SLL = reg2<<sa; SRL = logical right shift.
  - SRA = arithmetic right shift, sign-filled from reg2_i[31].
- alusel MOVE: MFHI gives hi_o, MFLO gives lo_o (register values, no bypass needed).
- alusel NOP, or an unknown aluop: wdata_o=0.
- Divider FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If aluop_i is DIV/DIVU and flush_i=0: stallreq_o=1 combinationally.
    - If reg2_i≠0: at the next edge latch the operands and go to BUSY with counter=0.
    - If reg2_i=0: go directly to DONE.
  - Otherwise stallreq_o=0.
- DIV operand handling: the divider latches |reg1|, |reg2| and both sign bits. DIVU latches the operands unsigned.
- BUSY:
  - stallreq_o=1.
  - Each cycle, one restoring step: shift the remainder:quotient pair left by 1, trial-subtract the divisor, set the quotient bit on no-borrow; counter+1.
  - When counter reaches DIV_ITER-1, go to DONE at the next edge.
- DONE:
  - stallreq_o=0, so the pipeline advances at the next edge.
  - At that same edge, write LO=quotient and HI=remainder, then return to IDLE. The next instruction sees the new HI/LO.
- Sign fix-up for DIV:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU): HI=LO=0, written on leaving DONE.
- Latency:
  - Nonzero divisor: 34 cycles in EX (1 IDLE + 32 BUSY + 1 DONE).
  - Zero divisor: 2 cycles.
  - All other ops: 1 cycle, no stall.
- flush_i=1 in any state:
  - Next state is IDLE; no HI/LO write; stallreq_o=0 in that cycle.
- Operands in BUSY: reg1_i/reg2_i changing during BUSY has no effect; the latched copies are used.

Test Plan:
- AND reg1=0xF0F0_1234, reg2=0x0FF0_FFFF, wreg_i=1, wd_i=5 -> same cycle wdata_o=0x00F0_1234, wreg_o=1, wd_o=5, stallreq_o=0.
- SRA reg1=4, reg2=0x8000_0010 -> wdata_o=0xF800_0001. SRL with the same operands -> 0x0800_0001.
- DIV reg1=0xFFFF_FFF9 (-7), reg2=2 -> stallreq_o high for exactly 33 cycles. Then LO=0xFFFF_FFFD and HI=0xFFFF_FFFF; a following MFLO gives wdata_o=0xFFFF_FFFD.
- DIVU reg1=0xFFFF_FFFF, reg2=0x10 -> LO=0x0FFF_FFFF, HI=0xF after 34 cycles. DIVU by 0 -> stall for 1 cycle, HI=LO=0.
- Start DIV, then assert rst at BUSY cycle 10 -> stallreq_o=0 and hi_o=lo_o=0 before the next edge; FSM is in IDLE after release.
- Start DIV, flush_i=1 at BUSY cycle 5 -> stallreq_o=0 the same cycle; HI/LO keep their prior values (preload via a completed DIVU 100/7: LO=14, HI=2).
